// File: rtl/mem_stage_dmem_ctrl_if.sv
// Data-memory request/ack bus between the MEM-stage controller (master) and the data memory (slave).
// Handshake: master raises dm_req with dm_we/dm_addr/dm_be/dm_wdata stable and holds them until a cycle
// in which the slave drives dm_ack=1; that cycle completes the transfer and dm_rdata is valid in it.
interface mem_stage_dmem_ctrl_if;
  logic        dm_req;
  logic        dm_we;
  logic [29:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_stage_dmem_ctrl.sv
// MEM-stage data-memory controller: turns load/store controls into one req/ack access and stalls until done.
// Optional abort on a silent memory is enabled by defining DM_TIMEOUT_EN.
module mem_stage_dmem_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         MEM_Valid,
  input  logic                         MEM_DmRd,
  input  logic                         MEM_DmWr,
  input  logic [1:0]                   MEM_SType,
  input  logic [31:0]                  MEM_AluOut,
  input  logic [31:0]                  MEM_RtData,
  mem_stage_dmem_ctrl_if.master        dm,
  output logic [31:0]                  MEM_DmResult,
  output logic                         MEM_Stall,
  output logic                         MEM_AccErr,
  output logic [1:0]                   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [29:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] result_q;

  logic        access;
  logic        aligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic        launch;
  logic        capture;
  logic        clear_res;
  logic        abort;
  logic        mis_err;

  // Reset also masks the pipeline request so nothing stalls or errors while rst_n is low.
  assign access = rst_n & MEM_Valid & (MEM_DmRd | MEM_DmWr);

  always_comb begin
    aligned    = 1'b1;
    be_calc    = 4'hF;
    wdata_calc = MEM_RtData;
    case (MEM_SType)
      2'b01: begin
        aligned    = ~MEM_AluOut[0];
        be_calc    = MEM_AluOut[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{MEM_RtData[15:0]}};
      end
      2'b10: begin
        aligned    = 1'b1;
        be_calc    = 4'b0001 << MEM_AluOut[1:0];
        wdata_calc = {4{MEM_RtData[7:0]}};
      end
      default: begin
        aligned    = (MEM_AluOut[1:0] == 2'b00);
        be_calc    = 4'hF;
        wdata_calc = MEM_RtData;
      end
    endcase
    if (!MEM_DmWr) be_calc = 4'hF;
  end

`ifdef DM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             to_q;
  logic             timeout_hit;

  // The counter holds the number of BUSY cycles already elapsed, so the last allowed one sees TIMEOUT_CYCLES-1.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      to_q <= abort;
      if (launch)                cnt_q <= '0;
      else if (state_q == BUSY)  cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  logic timeout_hit;
  logic to_q;
  assign timeout_hit = 1'b0;
  assign to_q        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    launch    = 1'b0;
    capture   = 1'b0;
    clear_res = 1'b0;
    abort     = 1'b0;
    mis_err   = 1'b0;
    MEM_Stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            launch    = 1'b1;
            MEM_Stall = 1'b1;
            state_d   = BUSY;
          end else begin
            mis_err   = 1'b1;
            clear_res = 1'b1;
          end
        end
      end
      BUSY: begin
        MEM_Stall = 1'b1;
        if (dm.dm_ack) begin
          capture = ~we_q;
          state_d = DONE;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      // DONE lets the pipeline advance on this edge, so the same instruction is never issued twice.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    MEM_AccErr = mis_err | ((state_q == DONE) & to_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      result_q <= '0;
    end else begin
      if (launch) begin
        we_q    <= MEM_DmWr;
        addr_q  <= MEM_AluOut[31:2];
        be_q    <= be_calc;
        wdata_q <= wdata_calc;
      end
      if (capture)                  result_q <= dm.dm_rdata;
      else if (clear_res || abort)  result_q <= '0;
    end
  end

  assign dm.dm_req     = (state_q == BUSY);
  assign dm.dm_we      = we_q;
  assign dm.dm_addr    = addr_q;
  assign dm.dm_be      = be_q;
  assign dm.dm_wdata   = wdata_q;
  assign MEM_DmResult  = result_q;
  assign dbg_state     = state_q;

endmodule
